// File: rtl/cpu_pkg.sv
// Shared MIPS encoding constants, instruction-kind enum and encoder FSM states.
// The control unit imports the same opcode/funct values so encode and decode stay in step.
package cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      K_ADD = 3'd0,
      K_SUB = 3'd1,
      K_AND = 3'd2,
      K_OR  = 3'd3,
      K_SLT = 3'd4,
      K_LW  = 3'd5,
      K_SW  = 3'd6,
      K_BEQ = 3'd7
   } kind_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational MIPS word packer: kind + register fields + immediate -> 32-bit instruction.
// Zero latency, no handshake; rd is dropped for I-type kinds and imm for R-type kinds.
module instr_pack
   import cpu_pkg::*;
(
   input  kind_t       kind,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] imm,
   output logic [31:0] word
);

   always_comb begin
      word = '0;
      unique case (kind)
         K_ADD: word = {OP_RTYPE, rs, rt, rd, 5'b0, FN_ADD};
         K_SUB: word = {OP_RTYPE, rs, rt, rd, 5'b0, FN_SUB};
         K_AND: word = {OP_RTYPE, rs, rt, rd, 5'b0, FN_AND};
         K_OR:  word = {OP_RTYPE, rs, rt, rd, 5'b0, FN_OR};
         K_SLT: word = {OP_RTYPE, rs, rt, rd, 5'b0, FN_SLT};
         K_LW:  word = {OP_LW,  rs, rt, imm};
         K_SW:  word = {OP_SW,  rs, rt, imm};
         K_BEQ: word = {OP_BEQ, rs, rt, imm};
         default: word = '0;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Streaming encoder: a programmed run of N requests becomes N addressed words, 1 cycle accept->out_valid.
// One-entry output register; in_ready drops while a word is stalled by !out_ready.
module instr_encoder
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  count,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_kind,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [15:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              busy,
   output logic              done
);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  remaining_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       word;
   logic              accept, pop, load;

   instr_pack u_pack (
      .kind (kind_t'(in_kind)),
      .rs   (in_rs),
      .rt   (in_rt),
      .rd   (in_rd),
      .imm  (in_imm),
      .word (word)
   );

   assign in_ready = (state_q == S_RUN) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign pop      = out_valid && out_ready;
   assign load     = (state_q == S_IDLE) && start && (count != '0);
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = (count != '0) ? S_RUN : S_DONE;
         S_RUN:   if (accept && remaining_q == CNT_W'(1)) state_d = S_DRAIN;
         S_DRAIN: if (!out_valid || out_ready) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         addr_q      <= '0;
         out_valid   <= 1'b0;
         out_instr   <= '0;
         out_addr    <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            // word-align the base; the mask keeps every base_addr bit in use
            addr_q      <= base_addr & ~ADDR_W'(3);
            remaining_q <= count;
         end else if (accept) begin
            addr_q      <= addr_q + ADDR_W'(4);
            remaining_q <= remaining_q - CNT_W'(1);
         end
         if (accept) begin
            out_valid <= 1'b1;
            out_instr <= word;
            out_addr  <= addr_q;
         end else if (pop) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, run sequencing, backpressure, wrap, async reset.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic [7:0]  count = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_kind = '0;
   logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
   logic [15:0] in_imm = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_addr;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;

   instr_encoder #(.ADDR_W(32), .CNT_W(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .base_addr (base_addr),
      .count     (count),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_kind   (in_kind),
      .in_rs     (in_rs),
      .in_rt     (in_rt),
      .in_rd     (in_rd),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_addr  (out_addr),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm);
      in_valid = 1'b1;
      in_kind  = k;
      in_rs    = rs;
      in_rt    = rt;
      in_rd    = rd;
      in_imm   = imm;
   endtask

   task automatic begin_run(input logic [31:0] base, input logic [7:0] n);
      start     = 1'b1;
      base_addr = base;
      count     = n;
      tick();
      start     = 1'b0;
   endtask

   initial begin
      // reset state
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #2;
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_instr", out_instr,      32'h0);
      chk("rst_out_addr",  out_addr,       32'h0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_done",      32'(done),      32'd0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // single add, unaligned base forced to 0x100, imm ignored for R-type
      start = 1'b1; base_addr = 32'h102; count = 8'd1;
      chk("t1_busy_before", 32'(busy), 32'd0);
      tick();
      start = 1'b0;
      chk("t1_busy_after_start", 32'(busy),     32'd1);
      chk("t1_in_ready",         32'(in_ready), 32'd1);
      req(3'd0, 5'd1, 5'd2, 5'd3, 16'hFFFF);
      tick();
      in_valid = 1'b0;
      chk("t1_instr",     out_instr,           32'h00221820);
      chk("t1_addr",      out_addr,            32'h100);
      chk("t1_valid",     32'(out_valid),      32'd1);
      chk("t1_no_ready",  32'(in_ready),       32'd0);
      chk("t1_done_pre",  32'(done),           32'd0);
      out_ready = 1'b1;
      tick();
      chk("t1_done",      32'(done),           32'd1);
      chk("t1_busy_done", 32'(busy),           32'd1);
      chk("t1_popped",    32'(out_valid),      32'd0);
      tick();
      chk("t1_done_drop", 32'(done),           32'd0);
      chk("t1_idle",      32'(busy),           32'd0);

      // three I-type words back to back, rd ignored for lw
      begin_run(32'h100, 8'd3);
      req(3'd5, 5'd16, 5'd8, 5'd31, 16'h0004);
      tick();
      chk("t2_w0", out_instr, 32'h8E080004);
      chk("t2_a0", out_addr,  32'h100);
      chk("t2_rdy0", 32'(in_ready), 32'd1);
      req(3'd6, 5'd1, 5'd2, 5'd0, 16'h0008);
      tick();
      chk("t2_w1", out_instr, 32'hAC220008);
      chk("t2_a1", out_addr,  32'h104);
      req(3'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF);
      tick();
      in_valid = 1'b0;
      chk("t2_w2", out_instr, 32'h1022FFFF);
      chk("t2_a2", out_addr,  32'h108);
      chk("t2_v2", 32'(out_valid), 32'd1);
      chk("t2_drain_rdy", 32'(in_ready), 32'd0);
      tick();
      chk("t2_done", 32'(done), 32'd1);
      tick();
      chk("t2_idle", 32'(busy), 32'd0);

      // backpressure, then simultaneous pop and accept
      out_ready = 1'b0;
      begin_run(32'h200, 8'd2);
      req(3'd4, 5'd5, 5'd6, 5'd4, 16'h0);
      tick();
      req(3'd1, 5'd3, 5'd4, 5'd5, 16'h0);
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_instr", out_instr,      32'h00A6202A);
         chk("t3_hold_addr",  out_addr,       32'h200);
         chk("t3_hold_rdy",   32'(in_ready),  32'd0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("t3_swap_valid", 32'(out_valid), 32'd1);
      chk("t3_swap_instr", out_instr,      32'h00642822);
      chk("t3_swap_addr",  out_addr,       32'h204);
      tick();
      chk("t3_done", 32'(done), 32'd1);
      tick();

      // pop without accept empties the register mid-run
      begin_run(32'h0, 8'd2);
      req(3'd2, 5'd31, 5'd31, 5'd31, 16'h0);
      tick();
      in_valid = 1'b0;
      chk("t4_and", out_instr, 32'h03FFF824);
      tick();
      chk("t4_gap_valid", 32'(out_valid), 32'd0);
      chk("t4_gap_busy",  32'(busy),      32'd1);
      req(3'd3, 5'd7, 5'd0, 5'd9, 16'h0);
      tick();
      in_valid = 1'b0;
      chk("t4_or",   out_instr, 32'h00E04825);
      chk("t4_addr", out_addr,  32'h4);
      tick();
      chk("t4_done", 32'(done), 32'd1);
      tick();

      // zero-count run, start while in DONE ignored
      start = 1'b1; base_addr = 32'h0; count = 8'd0;
      tick();
      count = 8'd5;
      chk("t5_zero_done",  32'(done),      32'd1);
      chk("t5_zero_busy",  32'(busy),      32'd1);
      chk("t5_zero_valid", 32'(out_valid), 32'd0);
      tick();
      start = 1'b0;
      chk("t5_zero_idle", 32'(busy), 32'd0);
      chk("t5_zero_ndone", 32'(done), 32'd0);
      tick();
      chk("t5_stay_idle", 32'(busy), 32'd0);

      // start during RUN must not reload count or address
      begin_run(32'h300, 8'd2);
      start = 1'b1; base_addr = 32'h500; count = 8'd9;
      req(3'd0, 5'd1, 5'd2, 5'd3, 16'h0);
      tick();
      start = 1'b0;
      chk("t6_addr0", out_addr, 32'h300);
      tick();
      in_valid = 1'b0;
      chk("t6_addr1", out_addr, 32'h304);
      chk("t6_drain", 32'(in_ready), 32'd0);
      tick();
      chk("t6_done", 32'(done), 32'd1);
      tick();

      // address wrap
      begin_run(32'hFFFFFFFC, 8'd2);
      req(3'd7, 5'd0, 5'd0, 5'd0, 16'h0);
      tick();
      chk("t7_w0", out_instr, 32'h10000000);
      chk("t7_a0", out_addr,  32'hFFFFFFFC);
      req(3'd5, 5'd2, 5'd3, 5'd0, 16'h8000);
      tick();
      in_valid = 1'b0;
      chk("t7_w1", out_instr, 32'h8C438000);
      chk("t7_a1", out_addr,  32'h00000000);
      tick();
      chk("t7_done", 32'(done), 32'd1);
      tick();

      // async reset mid-run with a pending word
      out_ready = 1'b0;
      begin_run(32'h40, 8'd3);
      req(3'd0, 5'd1, 5'd2, 5'd3, 16'h0);
      tick();
      in_valid = 1'b0;
      chk("t8_pending", 32'(out_valid), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("t8_valid",  32'(out_valid), 32'd0);
      chk("t8_instr",  out_instr,      32'h0);
      chk("t8_addr",   out_addr,       32'h0);
      chk("t8_busy",   32'(busy),      32'd0);
      chk("t8_rdy",    32'(in_ready),  32'd0);
      chk("t8_done",   32'(done),      32'd0);
      tick();
      tick();
      chk("t8_no_done", 32'(done), 32'd0);
      reset_n = 1'b1;
      tick();
      chk("t8_no_done_after", 32'(done), 32'd0);
      out_ready = 1'b1;
      begin_run(32'h80, 8'd1);
      req(3'd3, 5'd7, 5'd0, 5'd9, 16'h0);
      tick();
      in_valid = 1'b0;
      chk("t8_new_instr", out_instr, 32'h00E04825);
      chk("t8_new_addr",  out_addr,  32'h80);
      tick();
      chk("t8_new_done", 32'(done), 32'd1);
      tick();
      chk("t8_new_idle", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming MIPS instruction encoder: accepts symbolic instruction requests (kind, register fields, immediate) over a valid/ready handshake and produces the 32-bit machine words that the control unit later decodes. It sits between the test/boot loader and instruction memory. It emits each encoded word with its byte address for a programmed run of N instructions starting at a base address. It covers exactly the subset the control unit decodes: add, sub, and, or, slt, lw, sw, beq.

## Interface
Parameters:
- ADDR_W, 32, width of byte address output
- CNT_W, 8, width of instruction-count register

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  reset; asynchronous assert, active-low
- start  in  1  one-cycle pulse; loads base_addr/count, honoured only in IDLE
- base_addr  in  ADDR_W  byte address of first word; low 2 bits forced to 0
- count  in  CNT_W  number of instructions in the run
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_kind  in  3  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 lw, 6 sw, 7 beq
- in_rs, in_rt, in_rd  in  5 each  register fields (rd ignored for kinds 5-7)
- in_imm  in  16  immediate/offset (ignored for kinds 0-4)
- out_valid  out  1  encoded word valid
- out_ready  in  1  sink accepts when out_valid && out_ready
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  byte address of out_instr
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at run completion

## Operation
- Encoding:
  - R-type: {6'b000000, rs, rt, rd, 5'b0, funct}; funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - lw: {6'b100011, rs, rt, imm}.
  - sw: {6'b101011, rs, rt, imm}.
  - beq: {6'b000100, rs, rt, imm}.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start with count != 0 loads addr_q = {base_addr[ADDR_W-1:2], 2'b00} and remaining = count, then goes to RUN. start with count == 0 goes straight to DONE.
  - RUN: each accept decrements remaining. The accept that takes remaining from 1 to 0 goes to DRAIN.
  - DRAIN: waits until the output register is empty, or emptied this cycle, then goes to DONE.
  - DONE: asserts done for one cycle, then returns to IDLE.
- start outside IDLE is ignored; base_addr/count are not re-sampled.
- Output register: one entry. in_ready = (state == RUN) && (!out_valid || out_ready).
- On accept: out_instr is loaded with the encoding, out_addr with addr_q, out_valid is set, and addr_q += 4.
- Output pop without an accept clears out_valid. Simultaneous pop and accept keeps out_valid at 1 with the new data.
- Address wraps modulo 2^ADDR_W; no error is raised.
- Reset mid-run abandons the run, including any pending output word; no done pulse is generated.

## Timing
- Reset values: in_ready 0, out_valid 0, out_instr 0, out_addr 0, busy 0, done 0; state IDLE, remaining 0, addr_q 0.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 word/cycle while out_ready is held high.
- Stall behaviour: while out_valid && !out_ready, out_instr and out_addr hold stable and in_ready = 0.
- Run timing: busy rises the cycle after start. done is asserted 1 cycle after the last word is popped (DRAIN→DONE), and busy falls the cycle after done.
- Zero-count run: start → DONE next cycle (done = 1, busy = 1) → IDLE.
- in_ready is a registered-state function; it does not depend combinationally on in_valid.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ
  - funct constants: FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT
  - the 3-bit kind enum
  - the FSM state typedef
- The control unit imports the same opcode/funct constants, so encoder and decoder cannot diverge.
- One combinational sub-module, instr_pack (kind, rs, rt, rd, imm → 32-bit word), holds the encoding. It is reusable by the bench as a golden model.

## Test plan
- Reset, start base 0x100 count 1, add rs1 rt2 rd3 → out_instr 0x00221820, out_addr 0x100, done 1 cycle after pop.
- Run count 3 with out_ready held 1: lw rs16 rt8 imm4, sw rs1 rt2 imm8, beq rs1 rt2 imm 0xFFFF → 0x8E080004 @0x100, 0xAC220008 @0x104, 0x1022FFFF @0x108 on consecutive cycles.
- Backpressure: slt rs5 rt6 rd4 with out_ready 0 for 5 cycles → 0x00A6202A held stable, in_ready 0, no second accept; the word is popped on the first cycle out_ready = 1.
- Zero-count run and start pulsed while busy → done after 1 cycle with no output; start during RUN is ignored (remaining and address unchanged).
- Wrap: base 0xFFFFFFFC, count 2 → addresses 0xFFFFFFFC then 0x00000000.
- Async reset asserted in RUN with out_valid 1 → all outputs 0 immediately, no done pulse; a new run then works normally.
